// File: rtl/ctrl_pkg.sv
// Shared definitions for the accumulator-machine controller and its ALU:
// controller state encoding, instruction opcodes and ALU operation selects.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH1 = 3'd0,
        FETCH2 = 3'd1,
        DECODE = 3'd2,
        OPADDR = 3'd3,
        MEMRD  = 3'd4,
        MEMWR  = 3'd5,
        HALT   = 3'd6
    } state_e;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JN  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_NOT  = 3'd5;

    // ALU operation for the memory-operand instructions completed in MEMRD.
    function automatic logic [2:0] alu_sel_for(input logic [3:0] opcode);
        case (opcode)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_PASS;
        endcase
    endfunction

    // States that wait on MEM_READY and are therefore covered by the timer.
    function automatic logic is_wait_state(input state_e s);
        return (s == FETCH2) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state timer: counts consecutive MEM_READY-low cycles inside a
// wait state and flags the cycle in which the wait limit is exhausted.
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,      // next cycle enters a wait state
    input  logic active_i,     // current cycle is a wait state
    input  logic mem_ready_i,
    output logic expired_o
);

    localparam int CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_WAIT_MAX);

    logic [CW-1:0] count_q;

    // Wait counter: cleared on entry, advances on each stalled cycle, holds at the limit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so every register samples pre-edge values.
        if (reset) begin
            count_q <= '0;
        end else if (start_i) begin
            count_q <= '0;
        end else if (active_i && !mem_ready_i && (count_q != LIMIT)) begin
            count_q <= count_q + CW'(1);
        end
    end

    // A ready memory in the limit cycle still completes, so only a stalled one expires.
    assign expired_o = active_i && !mem_ready_i && (count_q == LIMIT);

endmodule

// File: rtl/control_unit.sv
// Hardwired controller for an 8-bit accumulator machine.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to halt on opcodes B-E and
// raise ILLEGAL; by default those opcodes execute as NOP and ILLEGAL is 0.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] OPCODE,
    input  logic       Z_FLAG,
    input  logic       N_FLAG,
    input  logic       MEM_READY,
    output logic       LOAD_MAR,
    output logic       ADDR_SEL,
    output logic       MEM_RD,
    output logic       MEM_WR,
    output logic       LOAD_IR,
    output logic       INC_PC,
    output logic       LOAD_PC,
    output logic       LOAD_AC,
    output logic [2:0] ALU_SEL,
    output logic       HALTED,
    output logic       TIMEOUT,
    output logic       ILLEGAL
);

    state_e state_q, state_d;
    logic   timeout_q;
    logic   wait_expired;
    logic   wait_start;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic   illegal_q;
    logic   illegal_trap;
`endif

    assign wait_start = is_wait_state(state_d) && (state_d != state_q);

    mem_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_wait_timer (
        .clk         (clk),
        .reset       (reset),
        .start_i     (wait_start),
        .active_i    (is_wait_state(state_q)),
        .mem_ready_i (MEM_READY),
        .expired_o   (wait_expired)
    );

    // State register and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH1;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wait_expired) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (illegal_trap) begin
            illegal_q <= 1'b1;
        end
    end
    assign ILLEGAL = illegal_q && !reset;
`else
    assign ILLEGAL = 1'b0;
`endif

    assign TIMEOUT = timeout_q && !reset;

    // Next-state and strobe decode; reset forces every strobe low.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d  = state_q;
        LOAD_MAR = 1'b0;
        ADDR_SEL = 1'b0;
        MEM_RD   = 1'b0;
        MEM_WR   = 1'b0;
        LOAD_IR  = 1'b0;
        INC_PC   = 1'b0;
        LOAD_PC  = 1'b0;
        LOAD_AC  = 1'b0;
        ALU_SEL  = ALU_PASS;
        HALTED   = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_trap = 1'b0;
`endif
        if (!reset) begin
            case (state_q)
                FETCH1: begin
                    LOAD_MAR = 1'b1;
                    state_d  = FETCH2;
                end
                FETCH2: begin
                    MEM_RD = 1'b1;
                    if (MEM_READY) begin
                        LOAD_IR = 1'b1;
                        INC_PC  = 1'b1;
                        state_d = DECODE;
                    end else if (wait_expired) begin
                        state_d = HALT;
                    end
                end
                DECODE: begin
                    state_d = FETCH1;
                    case (OPCODE)
                        OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = OPADDR;
                        OP_NOT: begin
                            LOAD_AC = 1'b1;
                            ALU_SEL = ALU_NOT;
                        end
                        OP_JMP:  LOAD_PC = 1'b1;
                        OP_JZ:   LOAD_PC = Z_FLAG;
                        OP_JN:   LOAD_PC = N_FLAG;
                        OP_HLT:  state_d = HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        4'hB, 4'hC, 4'hD, 4'hE: begin
                            illegal_trap = 1'b1;
                            state_d      = HALT;
                        end
`endif
                        default: state_d = FETCH1;
                    endcase
                end
                OPADDR: begin
                    LOAD_MAR = 1'b1;
                    ADDR_SEL = 1'b1;
                    state_d  = (OPCODE == OP_STA) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    MEM_RD = 1'b1;
                    if (MEM_READY) begin
                        LOAD_AC = 1'b1;
                        ALU_SEL = alu_sel_for(OPCODE);
                        state_d = FETCH1;
                    end else if (wait_expired) begin
                        state_d = HALT;
                    end
                end
                MEMWR: begin
                    MEM_WR = 1'b1;
                    if (MEM_READY) begin
                        state_d = FETCH1;
                    end else if (wait_expired) begin
                        state_d = HALT;
                    end
                end
                HALT: begin
                    HALTED = 1'b1;
                end
                default: state_d = FETCH1;
            endcase
        end
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15: max consecutive cycles a memory wait state may see MEM_READY low before timeout.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- OPCODE  in  4  IR[7:4] from the instruction register.
- Z_FLAG  in  1  AC == 0.
- N_FLAG  in  1  AC[7] (sign).
- MEM_READY  in  1  memory completes current read/write this cycle.
- LOAD_MAR  out  1  MAR captures the selected address.
- ADDR_SEL  out  1  0 = PC, 1 = IR operand field.
- MEM_RD  out  1  memory read request.
- MEM_WR  out  1  memory write request (data = AC).
- LOAD_IR  out  1  IR captures memory data.
- INC_PC  out  1  PC increments.
- LOAD_PC  out  1  PC loads IR operand field.
- LOAD_AC  out  1  accumulator captures ALU result Z.
- ALU_SEL  out  3  ALU op: 0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT.
- HALTED  out  1  controller in HALT state.
- TIMEOUT  out  1  sticky; memory wait exceeded MEM_WAIT_MAX.
- ILLEGAL  out  1  sticky; illegal opcode trapped (see REQ-020).

Function
REQ-003 SHALL implement FSM states FETCH1, FETCH2, DECODE, OPADDR, MEMRD, MEMWR, HALT.
REQ-004 FETCH1 SHALL assert LOAD_MAR with ADDR_SEL=0 for exactly one cycle, then go to FETCH2.
REQ-005 FETCH2 SHALL hold MEM_RD=1; in the cycle MEM_READY=1 it SHALL assert LOAD_IR and INC_PC together and go to DECODE.
REQ-006 DECODE SHALL branch on OPCODE: 0 NOP -> FETCH1; 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR -> OPADDR; 7 NOT -> assert LOAD_AC with ALU_SEL=5 then FETCH1; 8 JMP -> assert LOAD_PC then FETCH1; 9 JZ -> LOAD_PC=Z_FLAG then FETCH1; A JN -> LOAD_PC=N_FLAG then FETCH1; F HLT -> HALT.
REQ-007 OPADDR SHALL assert LOAD_MAR with ADDR_SEL=1 for one cycle, then go to MEMWR for STA, else MEMRD.
REQ-008 MEMRD SHALL hold MEM_RD=1; in the MEM_READY cycle it SHALL assert LOAD_AC with ALU_SEL = LDA:0, ADD:1, SUB:2, AND:3, OR:4 and go to FETCH1.
REQ-009 MEMWR SHALL hold MEM_WR=1 until the MEM_READY cycle, then go to FETCH1; LOAD_AC SHALL stay 0.
REQ-010 OPCODE SHALL be sampled only in DECODE, OPADDR and MEMRD; IR is stable there by construction.
REQ-011 LOAD_AC SHALL be 1 only in the cycles of REQ-006 (NOT) and REQ-008; ALU_SEL is don't-care elsewhere but SHALL drive 0.
REQ-012 MEM_RD and MEM_WR SHALL never both be 1.
REQ-013 A wait counter SHALL clear on entry to FETCH2/MEMRD/MEMWR and increment each cycle MEM_READY=0 there.
REQ-014 When the counter equals MEM_WAIT_MAX with MEM_READY=0, next state SHALL be HALT and TIMEOUT SHALL set; MEM_READY=1 in that same cycle completes normally (no timeout).
REQ-015 HALT SHALL assert HALTED=1, all other strobes 0, and persist until reset.
REQ-016 Instruction latencies: NOP/JMP/JZ/JN/NOT = 3 cycles; LDA/ADD/SUB/AND/OR/STA = 5 cycles, plus wait cycles.

Reset
REQ-017 While reset=1 at a posedge, state SHALL become FETCH1, wait counter 0, TIMEOUT and ILLEGAL 0.
REQ-018 While reset=1, all outputs SHALL be driven 0 combinationally; reset mid-instruction abandons it with no further strobes.
REQ-019 First cycle after reset release SHALL assert LOAD_MAR, ADDR_SEL=0.

Configuration
REQ-020 With CTRL_ILLEGAL_TRAP_EN defined, opcodes B-E in DECODE SHALL go to HALT and set ILLEGAL; without it they SHALL behave as NOP and ILLEGAL SHALL be tied 0.

Structure
REQ-021 Package ctrl_pkg SHALL hold the state enum, opcode constants and ALU_SEL constants, shared with the ALU.
REQ-022 Sub-module mem_wait_timer SHALL hold the wait counter and timeout compare.

Verification
REQ-023 Reset, MEM_READY=1, fetch OPCODE=1 (LDA) -> LOAD_AC=1 ALU_SEL=0 in cycle 5 after release.
REQ-024 OPCODE=9, Z_FLAG=1 then Z_FLAG=0 -> LOAD_PC=1 in DECODE first, 0 second.
REQ-025 OPCODE=2, MEM_READY low 3 cycles in MEMWR -> MEM_WR=1 for 4 cycles, LOAD_AC never 1.
REQ-026 MEM_WAIT_MAX=15, MEM_READY held 0 in FETCH2 -> HALT, TIMEOUT=1 after 16 cycles; MEM_READY=1 at count 15 -> no timeout.
REQ-027 OPCODE=C with/without CTRL_ILLEGAL_TRAP_EN -> HALTED=1 ILLEGAL=1 / return to FETCH1.
REQ-028 reset=1 during MEMRD -> next cycle all outputs 0; after release FETCH1.
